cpu_mem_bus_arbiter: RTL and testbench

CPU_MEM_BUS_ARBITER -- requirements
Module: CPU_mem_bus_arbiter

---
 rtl/cpu_mem_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cpu_mem_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_bus_arbiter.sv
// ============================================================================
// Module  : cpu_mem_bus_arbiter
// Brief   : Round-robin line arbiter between I-cache and D-cache onto one memory port.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif
`ifndef LINE_WIDTH
`define LINE_WIDTH 512
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif

module cpu_mem_bus_arbiter #(
  parameter int LINE_ADDR_WIDTH = `PHYSICAL_ADDR_WIDTH - $clog2(`LINE_WIDTH/`BYTE_WIDTH),
  parameter int LINE_WIDTH      = `LINE_WIDTH,
  parameter int TIMEOUT         = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [1:0]                      i_req_read,
  input  logic [1:0]                      i_req_write,
  input  logic [1:0][LINE_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [1:0][LINE_WIDTH-1:0]      i_req_data,
  output logic [1:0]                      o_req_available,
  output logic [1:0]                      o_resp_valid,
  output logic [LINE_ADDR_WIDTH-1:0]      o_resp_addr,
  output logic [LINE_WIDTH-1:0]           o_resp_data,
  output logic                            o_mem_read,
  output logic                            o_mem_write,
  output logic [LINE_ADDR_WIDTH-1:0]      o_mem_addr,
  output logic [LINE_WIDTH-1:0]           o_mem_wdata,
  input  logic                            i_mem_ready,
  input  logic                            i_mem_rvalid,
  input  logic [LINE_WIDTH-1:0]           i_mem_rdata,
  output logic                            o_busy,
  output logic                            o_timeout_err
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t                     r_state,       w_state_nxt;
  logic                       r_rr_ptr,      w_rr_ptr_nxt;
  logic                       r_owner,       w_owner_nxt;
  logic                       r_op_write,    w_op_write_nxt;
  logic [LINE_ADDR_WIDTH-1:0] r_addr,        w_addr_nxt;
  logic [LINE_WIDTH-1:0]      r_wdata,       w_wdata_nxt;
  logic [c_CNT_W-1:0]         r_wait_cnt,    w_wait_cnt_nxt;
  logic [LINE_ADDR_WIDTH-1:0] r_resp_addr,   w_resp_addr_nxt;
  logic [LINE_WIDTH-1:0]      r_resp_data,   w_resp_data_nxt;
  logic                       r_timeout_err, w_timeout_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= 1'b0;
      r_owner       <= 1'b0;
      r_op_write    <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wait_cnt    <= '0;
      r_resp_addr   <= '0;
      r_resp_data   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_owner       <= w_owner_nxt;
      r_op_write    <= w_op_write_nxt;
      r_addr        <= w_addr_nxt;
      r_wdata       <= w_wdata_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_resp_addr   <= w_resp_addr_nxt;
      r_resp_data   <= w_resp_data_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_owner_nxt       = r_owner;
    w_op_write_nxt    = r_op_write;
    w_addr_nxt        = r_addr;
    w_wdata_nxt       = r_wdata;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_resp_addr_nxt   = r_resp_addr;
    w_resp_data_nxt   = r_resp_data;
    w_timeout_err_nxt = r_timeout_err;

    case (r_state)
      ST_IDLE: begin
        if (i_req_read[r_rr_ptr] || i_req_write[r_rr_ptr]) begin
          w_owner_nxt    = r_rr_ptr;
          // A simultaneous write is dropped in favour of the read.
          w_op_write_nxt = ~i_req_read[r_rr_ptr];
          w_addr_nxt     = i_req_addr[r_rr_ptr];
          w_wdata_nxt    = i_req_data[r_rr_ptr];
          w_state_nxt    = ST_ISSUE;
        end else begin
          w_rr_ptr_nxt = ~r_rr_ptr;
        end
      end
      ST_ISSUE: begin
        if (i_mem_ready) begin
          if (r_op_write) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = ~r_owner;
          end else begin
            w_state_nxt    = ST_WAIT_RD;
            w_wait_cnt_nxt = '0;
          end
        end
      end
      ST_WAIT_RD: begin
        if (i_mem_rvalid) begin
          w_resp_addr_nxt = r_addr;
          w_resp_data_nxt = i_mem_rdata;
          w_state_nxt     = ST_RESP;
        end else if (r_wait_cnt == c_CNT_LAST) begin
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = ST_IDLE;
          w_rr_ptr_nxt      = ~r_owner;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      ST_RESP: begin
        w_state_nxt  = ST_IDLE;
        w_rr_ptr_nxt = ~r_owner;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // All outputs decode registered state only; no path from request inputs.
  always_comb begin
    o_req_available = 2'b00;
    o_resp_valid    = 2'b00;
    if (r_state == ST_IDLE) begin
      o_req_available = r_rr_ptr ? 2'b10 : 2'b01;
    end
    if (r_state == ST_RESP) begin
      o_resp_valid = r_owner ? 2'b10 : 2'b01;
    end
  end

  assign o_resp_addr   = r_resp_addr;
  assign o_resp_data   = r_resp_data;
  assign o_mem_read    = (r_state == ST_ISSUE) && !r_op_write;
  assign o_mem_write   = (r_state == ST_ISSUE) && r_op_write;
  assign o_mem_addr    = r_addr;
  assign o_mem_wdata   = r_wdata;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem_bus_arbiter.sv
// ============================================================================
// Module  : tb_cpu_mem_bus_arbiter
// Brief   : Directed self-checking bench for cpu_mem_bus_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cpu_mem_bus_arbiter;

  localparam int AW = 26;
  localparam int DW = 512;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           req_read;
  logic [1:0]           req_write;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][DW-1:0]   req_data;
  logic [1:0]           req_available;
  logic [1:0]           resp_valid;
  logic [AW-1:0]        resp_addr;
  logic [DW-1:0]        resp_data;
  logic                 mem_read;
  logic                 mem_write;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic                 mem_ready;
  logic                 mem_rvalid;
  logic [DW-1:0]        mem_rdata;
  logic                 busy;
  logic                 timeout_err;

  int checks   = 0;
  int failures = 0;

  cpu_mem_bus_arbiter #(
    .LINE_ADDR_WIDTH(AW),
    .LINE_WIDTH     (DW),
    .TIMEOUT        (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_read     (req_read),
    .i_req_write    (req_write),
    .i_req_addr     (req_addr),
    .i_req_data     (req_data),
    .o_req_available(req_available),
    .o_resp_valid   (resp_valid),
    .o_resp_addr    (resp_addr),
    .o_resp_data    (resp_data),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_ready    (mem_ready),
    .i_mem_rvalid   (mem_rvalid),
    .i_mem_rdata    (mem_rdata),
    .o_busy         (busy),
    .o_timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_avail(input int idx);
    bit seen = 0;
    for (int n = 0; n < 4 && !seen; n++) begin
      if (req_available[idx]) seen = 1;
      else tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_avail[%0d]: available=%b never granted", idx, req_available);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_read = '0; req_write = '0; req_addr = '0; req_data = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    tick(); tick();
    checks++; if (req_available !== 2'b01) begin failures++; $display("FAIL rst_avail: got %b want 01", req_available); end
    checks++; if ({busy, mem_read, mem_write, timeout_err, resp_valid} !== 6'b0) begin failures++;
      $display("FAIL rst_outs: busy/rd/wr/tmo/rv got %b want 000000", {busy, mem_read, mem_write, timeout_err, resp_valid}); end
    checks++; if (resp_addr !== '0 || mem_addr !== '0) begin failures++; $display("FAIL rst_addr: resp %h mem %h want 0", resp_addr, mem_addr); end
    rst_n = 1'b1;
    checks++; if (req_available !== 2'b01) begin failures++; $display("FAIL rel_avail: got %b want 01", req_available); end
    tick();
    checks++; if (req_available !== 2'b10) begin failures++; $display("FAIL idle_toggle1: got %b want 10", req_available); end
    tick();
    checks++; if (req_available !== 2'b01) begin failures++; $display("FAIL idle_toggle2: got %b want 01", req_available); end
  endtask

  task automatic test_icache_read();
    logic [DW-1:0] exp_d = {64{8'hA5}};
    req_read[0] = 1; req_addr[0] = 26'h100;
    tick();
    req_read = '0;
    checks++; if (!(mem_read === 1 && mem_write === 0 && mem_addr === 26'h100 && busy === 1 && req_available === 2'b00)) begin failures++;
      $display("FAIL ic_issue: rd=%b wr=%b addr=%h busy=%b avail=%b want 1 0 100 1 00", mem_read, mem_write, mem_addr, busy, req_available); end
    mem_ready = 1;
    tick();
    mem_ready = 0;
    checks++; if (mem_read !== 0 || resp_valid !== 2'b00) begin failures++; $display("FAIL ic_wait: rd=%b rv=%b want 0 00", mem_read, resp_valid); end
    tick(); tick();
    mem_rvalid = 1; mem_rdata = exp_d;
    tick();
    mem_rvalid = 0; mem_rdata = '0;
    checks++; if (resp_valid !== 2'b01 || resp_addr !== 26'h100 || resp_data !== exp_d) begin failures++;
      $display("FAIL ic_resp: rv=%b addr=%h data=%h want 01 100 a5..", resp_valid, resp_addr, resp_data); end
    tick();
    checks++; if (resp_valid !== 2'b00 || req_available !== 2'b10 || busy !== 0) begin failures++;
      $display("FAIL ic_after: rv=%b avail=%b busy=%b want 00 10 0", resp_valid, req_available, busy); end
    checks++; if (resp_addr !== 26'h100 || resp_data !== exp_d) begin failures++; $display("FAIL ic_hold: addr=%h data=%h", resp_addr, resp_data); end
  endtask

  task automatic test_dcache_write();
    logic [DW-1:0] wd = {16{32'hDEAD_BEEF}};
    req_write[1] = 1; req_addr[1] = 26'h2F0; req_data[1] = wd;
    req_read[0] = 1; req_addr[0] = 26'h333;
    tick();
    req_write = '0; req_read = '0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (!(mem_write === 1 && mem_read === 0 && mem_addr === 26'h2F0 && mem_wdata === wd)) begin failures++;
        $display("FAIL dc_issue[%0d]: wr=%b rd=%b addr=%h wdata=%h", c, mem_write, mem_read, mem_addr, mem_wdata); end
      if (c == 2) mem_ready = 1;
      tick();
    end
    mem_ready = 0;
    checks++; if (!(mem_write === 0 && busy === 0 && resp_valid === 2'b00 && req_available === 2'b01)) begin failures++;
      $display("FAIL dc_done: wr=%b busy=%b rv=%b avail=%b want 0 0 00 01", mem_write, busy, resp_valid, req_available); end
  endtask

  task automatic test_alternate();
    logic [DW-1:0] d;
    int ow;
    wait_avail(0);
    req_read = 2'b11; req_addr[0] = 26'h010; req_addr[1] = 26'h020;
    for (int k = 0; k < 4; k++) begin
      ow = k % 2;
      d = {64{8'(k + 1)}};
      tick();
      checks++; if (mem_read !== 1 || mem_addr !== (ow ? 26'h020 : 26'h010)) begin failures++;
        $display("FAIL alt_grant[%0d]: rd=%b addr=%h owner %0d", k, mem_read, mem_addr, ow); end
      mem_ready = 1;
      tick();
      mem_ready = 0; mem_rvalid = 1; mem_rdata = d;
      tick();
      mem_rvalid = 0;
      checks++; if (resp_valid !== (ow ? 2'b10 : 2'b01) || resp_data !== d) begin failures++;
        $display("FAIL alt_resp[%0d]: rv=%b data=%h owner %0d", k, resp_valid, resp_data, ow); end
      tick();
      checks++; if (req_available !== (ow ? 2'b01 : 2'b10) || resp_valid !== 2'b00) begin failures++;
        $display("FAIL alt_next[%0d]: avail=%b rv=%b", k, req_available, resp_valid); end
    end
    req_read = '0;
  endtask

  task automatic test_rvalid_with_ready();
    logic [DW-1:0] early = {64{8'h11}};
    logic [DW-1:0] late  = {64{8'h22}};
    wait_avail(0);
    req_read[0] = 1; req_addr[0] = 26'h044;
    tick();
    req_read = '0;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = early;
    tick();
    mem_ready = 0; mem_rvalid = 0;
    checks++; if (resp_valid !== 2'b00 || busy !== 1) begin failures++; $display("FAIL rdy_rv_same: rv=%b busy=%b want 00 1", resp_valid, busy); end
    tick();
    checks++; if (resp_valid !== 2'b00 || busy !== 1) begin failures++; $display("FAIL rdy_rv_wait: rv=%b busy=%b want 00 1", resp_valid, busy); end
    mem_rvalid = 1; mem_rdata = late;
    tick();
    mem_rvalid = 0;
    checks++; if (resp_valid !== 2'b01 || resp_data !== late) begin failures++; $display("FAIL rdy_rv_resp: rv=%b data=%h", resp_valid, resp_data); end
    tick();
  endtask

  task automatic test_ready_stall();
    bit stable = 1;
    wait_avail(0);
    req_read[0] = 1; req_write[0] = 1; req_addr[0] = 26'h055;
    tick();
    req_read = '0; req_write = '0;
    for (int c = 0; c < 5; c++) begin
      if (!(mem_read === 1 && mem_write === 0 && mem_addr === 26'h055)) stable = 0;
      tick();
    end
    checks++; if (!stable) begin failures++; $display("FAIL stall_hold: rd=%b wr=%b addr=%h want 1 0 055", mem_read, mem_write, mem_addr); end
    mem_ready = 1;
    tick();
    mem_ready = 0;
    checks++; if (mem_read !== 0 || busy !== 1) begin failures++; $display("FAIL stall_accept: rd=%b busy=%b want 0 1", mem_read, busy); end
    mem_rvalid = 1; mem_rdata = {64{8'h55}};
    tick();
    mem_rvalid = 0;
    checks++; if (resp_valid !== 2'b01 || resp_addr !== 26'h055) begin failures++; $display("FAIL stall_resp: rv=%b addr=%h", resp_valid, resp_addr); end
    tick();
  endtask

  task automatic test_timeout();
    bit no_resp = 1;
    wait_avail(1);
    req_read[1] = 1; req_addr[1] = 26'h077;
    tick();
    req_read = '0;
    mem_ready = 1;
    tick();
    mem_ready = 0;
    for (int c = 0; c < 63; c++) begin
      if (resp_valid !== 2'b00) no_resp = 0;
      tick();
    end
    checks++; if (busy !== 1 || timeout_err !== 0) begin failures++; $display("FAIL tmo_early: busy=%b tmo=%b want 1 0", busy, timeout_err); end
    tick();
    checks++; if (busy !== 0 || timeout_err !== 1 || req_available !== 2'b01) begin failures++;
      $display("FAIL tmo_fire: busy=%b tmo=%b avail=%b want 0 1 01", busy, timeout_err, req_available); end
    mem_rvalid = 1; mem_rdata = {64{8'h77}};
    for (int c = 0; c < 3; c++) begin
      tick();
      if (resp_valid !== 2'b00 || busy !== 0) no_resp = 0;
    end
    mem_rvalid = 0;
    checks++; if (!no_resp) begin failures++; $display("FAIL tmo_noresp: rv=%b busy=%b want 00 0", resp_valid, busy); end
    checks++; if (timeout_err !== 1) begin failures++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_midtxn();
    bit quiet = 1;
    wait_avail(0);
    req_read[0] = 1; req_addr[0] = 26'h099;
    tick();
    req_read = '0;
    mem_ready = 1;
    tick();
    mem_ready = 0;
    tick();
    rst_n = 0;
    #1;
    checks++; if ({busy, mem_read, mem_write, timeout_err, resp_valid} !== 6'b0) begin failures++;
      $display("FAIL rstmid_outs: busy/rd/wr/tmo/rv got %b want 000000", {busy, mem_read, mem_write, timeout_err, resp_valid}); end
    checks++; if (resp_addr !== '0 || resp_data !== '0 || mem_addr !== '0) begin failures++;
      $display("FAIL rstmid_regs: raddr=%h maddr=%h want 0", resp_addr, mem_addr); end
    tick();
    rst_n = 1;
    checks++; if (req_available !== 2'b01) begin failures++; $display("FAIL rstmid_avail: got %b want 01", req_available); end
    mem_rvalid = 1; mem_rdata = {64{8'h99}};
    for (int c = 0; c < 3; c++) begin
      tick();
      if (resp_valid !== 2'b00 || busy !== 0) quiet = 0;
    end
    mem_rvalid = 0;
    checks++; if (!quiet) begin failures++; $display("FAIL rstmid_noresp: rv=%b busy=%b want 00 0", resp_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_alternate();
    test_rvalid_with_ready();
    test_ready_stall();
    test_timeout();
    test_reset_midtxn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
